shift_reg_n: RTL and testbench

SHIFT_REG_N -- requirements
Module: shift_reg_n

---
 rtl/shift_reg_n.sv | 111 +++++++++++
 tb/tb_shift_reg_n.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/shift_reg_n.sv
// Multi-mode shift register: single steps on request, or a counted multi-step
// shift sequenced by an IDLE/SHIFT/DONE controller.
module shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [CNT_W-1:0] Amount,
  input  logic [1:0]       Mode,
  input  logic             Shift_In,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Shift_Out,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       eff_mode;

  function automatic logic [WIDTH-1:0] step_f(input logic [WIDTH-1:0] v,
                                              input logic [1:0] m,
                                              input logic si);
    logic [WIDTH-1:0] r;
    case (m)
      2'b00:   r = {si, v[WIDTH-1:1]};
      2'b01:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      2'b10:   r = {v[WIDTH-2:0], si};
      default: r = {v[0], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  // Load overrides everything (aborting a shift without a Done pulse);
  // Start and Shift_En are only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    mode_d  = mode_q;
    if (Load) begin
      data_d  = D;
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            mode_d = Mode;
            if (Amount == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
              count_d = Amount;
            end
          end else if (Shift_En) begin
            data_d = step_f(data_q, Mode, Shift_In);
          end
        end
        ST_SHIFT: begin
          data_d  = step_f(data_q, mode_q, Shift_In);
          count_d = count_q - 1'b1;
          if (count_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Busy      = (state_q == ST_SHIFT);
    Done      = (state_q == ST_DONE);
    eff_mode  = (state_q == ST_SHIFT) ? mode_q : Mode;
    Shift_Out = (eff_mode == 2'b10) ? data_q[WIDTH-1] : data_q[0];
  end

  assign Data_Out = data_q;
  assign Count    = count_q;

endmodule

// File: tb/tb_shift_reg_n.sv
// Scoreboard bench for shift_reg_n (WIDTH=8): stimulus pushes the expected
// post-edge outputs, a monitor pops and compares after every clock edge.
module tb_shift_reg_n;

  logic       Clk = 1'b0;
  logic       Reset, Load, Shift_En, Start, Shift_In;
  logic [7:0] D;
  logic [3:0] Amount;
  logic [1:0] Mode;
  logic [7:0] Data_Out;
  logic       Shift_Out, Busy, Done;
  logic [3:0] Count;

  typedef struct {
    string      nm;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic [3:0] cnt;
    logic       so;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  shift_reg_n #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .D(D), .Shift_En(Shift_En),
    .Start(Start), .Amount(Amount), .Mode(Mode), .Shift_In(Shift_In),
    .Data_Out(Data_Out), .Shift_Out(Shift_Out), .Busy(Busy), .Done(Done),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic tick(input string nm, input logic r, input logic ld,
                      input logic [7:0] dv, input logic se, input logic st,
                      input logic [3:0] am, input logic [1:0] md, input logic si,
                      input logic [7:0] ed, input logic eb, input logic edn,
                      input logic [3:0] ec, input logic eso);
    exp_t e;
    @(negedge Clk);
    #1;
    Reset = r; Load = ld; D = dv; Shift_En = se; Start = st;
    Amount = am; Mode = md; Shift_In = si;
    e.nm = nm; e.data = ed; e.busy = eb; e.done = edn; e.cnt = ec; e.so = eso;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({Data_Out, Busy, Done, Count, Shift_Out} === {e.data, e.busy, e.done, e.cnt, e.so}) begin
          passed++;
          $display("ok   %-10s data=%h busy=%b done=%b cnt=%0d so=%b",
                   e.nm, Data_Out, Busy, Done, Count, Shift_Out);
        end else begin
          $display("FAIL %-10s got data=%h busy=%b done=%b cnt=%0d so=%b exp data=%h busy=%b done=%b cnt=%0d so=%b",
                   e.nm, Data_Out, Busy, Done, Count, Shift_Out,
                   e.data, e.busy, e.done, e.cnt, e.so);
        end
      end
    end
  end

  initial begin : stim
    Reset = 1'b1; Load = 1'b0; D = '0; Shift_En = 1'b0; Start = 1'b0;
    Amount = '0; Mode = 2'b00; Shift_In = 1'b0;
    //    name        rst ld d      se st am md     si   data  b  dn cnt so
    tick("reset",     1, 0, 8'h00, 0, 0, 0, 2'd0, 0,   8'h00, 0, 0, 0, 0);
    // arithmetic right by 3
    tick("ld_b4",     0, 1, 8'hB4, 0, 0, 0, 2'd1, 0,   8'hB4, 0, 0, 0, 0);
    tick("st_asr3",   0, 0, 8'h00, 0, 1, 3, 2'd1, 0,   8'hB4, 1, 0, 3, 0);
    tick("asr_1",     0, 0, 8'h00, 0, 0, 0, 2'd1, 0,   8'hDA, 1, 0, 2, 0);
    tick("asr_2",     0, 0, 8'h00, 0, 0, 0, 2'd1, 0,   8'hED, 1, 0, 1, 1);
    tick("asr_done",  0, 0, 8'h00, 0, 0, 0, 2'd1, 0,   8'hF6, 0, 1, 0, 0);
    tick("asr_idle",  0, 0, 8'h00, 0, 0, 0, 2'd1, 0,   8'hF6, 0, 0, 0, 0);
    // rotate right by 4
    tick("ld_81",     0, 1, 8'h81, 0, 0, 0, 2'd3, 0,   8'h81, 0, 0, 0, 1);
    tick("st_ror4",   0, 0, 8'h00, 0, 1, 4, 2'd3, 0,   8'h81, 1, 0, 4, 1);
    tick("ror4_1",    0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'hC0, 1, 0, 3, 0);
    tick("ror4_2",    0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h60, 1, 0, 2, 0);
    tick("ror4_3",    0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h30, 1, 0, 1, 0);
    tick("ror4_done", 0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h18, 0, 1, 0, 0);
    tick("ror4_idle", 0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h18, 0, 0, 0, 0);
    // rotate right by full width returns the original value
    tick("ld_81b",    0, 1, 8'h81, 0, 0, 0, 2'd3, 0,   8'h81, 0, 0, 0, 1);
    tick("st_ror8",   0, 0, 8'h00, 0, 1, 8, 2'd3, 0,   8'h81, 1, 0, 8, 1);
    tick("ror8_1",    0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'hC0, 1, 0, 7, 0);
    tick("ror8_2",    0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h60, 1, 0, 6, 0);
    tick("ror8_3",    0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h30, 1, 0, 5, 0);
    tick("ror8_4",    0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h18, 1, 0, 4, 0);
    tick("ror8_5",    0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h0C, 1, 0, 3, 0);
    tick("ror8_6",    0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h06, 1, 0, 2, 0);
    tick("ror8_7",    0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h03, 1, 0, 1, 1);
    tick("ror8_done", 0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h81, 0, 1, 0, 1);
    tick("ror8_idle", 0, 0, 8'h00, 0, 0, 0, 2'd3, 0,   8'h81, 0, 0, 0, 1);
    // left shift with Shift_In=1
    tick("ld_01",     0, 1, 8'h01, 0, 0, 0, 2'd2, 1,   8'h01, 0, 0, 0, 0);
    tick("st_shl2",   0, 0, 8'h00, 0, 1, 2, 2'd2, 1,   8'h01, 1, 0, 2, 0);
    tick("shl2_1",    0, 0, 8'h00, 0, 0, 0, 2'd2, 1,   8'h03, 1, 0, 1, 0);
    tick("shl2_done", 0, 0, 8'h00, 0, 0, 0, 2'd2, 1,   8'h07, 0, 1, 0, 0);
    tick("shl2_idle", 0, 0, 8'h00, 0, 0, 0, 2'd2, 1,   8'h07, 0, 0, 0, 0);
    // Shift_Out follows bit 7 in left mode; single steps from IDLE
    tick("ld_c0",     0, 1, 8'hC0, 0, 0, 0, 2'd2, 0,   8'hC0, 0, 0, 0, 1);
    tick("se_left",   0, 0, 8'h00, 1, 0, 0, 2'd2, 0,   8'h80, 0, 0, 0, 1);
    tick("se_lsr",    0, 0, 8'h00, 1, 0, 0, 2'd0, 1,   8'hC0, 0, 0, 0, 0);
    // Mode latched at Start; live Mode input must not affect the shift
    tick("st_latch",  0, 0, 8'h00, 0, 1, 2, 2'd2, 0,   8'hC0, 1, 0, 2, 1);
    tick("latch_1",   0, 0, 8'h00, 0, 0, 0, 2'd0, 0,   8'h80, 1, 0, 1, 1);
    tick("latch_dn",  0, 0, 8'h00, 0, 0, 0, 2'd0, 0,   8'h00, 0, 1, 0, 0);
    // Load aborts a shift on its second SHIFT cycle, no Done follows
    tick("ld_a5",     0, 1, 8'hA5, 0, 0, 0, 2'd0, 0,   8'hA5, 0, 0, 0, 1);
    tick("st_lsr5",   0, 0, 8'h00, 0, 1, 5, 2'd0, 1,   8'hA5, 1, 0, 5, 1);
    tick("lsr5_1",    0, 0, 8'h00, 0, 0, 0, 2'd0, 1,   8'hD2, 1, 0, 4, 0);
    tick("abort_ld",  0, 1, 8'h3C, 0, 0, 0, 2'd0, 0,   8'h3C, 0, 0, 0, 0);
    tick("abort_nd",  0, 0, 8'h00, 0, 0, 0, 2'd0, 0,   8'h3C, 0, 0, 0, 0);
    // Amount=0 goes straight to DONE; Start during DONE is ignored
    tick("st_amt0",   0, 0, 8'h00, 0, 1, 0, 2'd0, 0,   8'h3C, 0, 1, 0, 0);
    tick("st_in_dn",  0, 0, 8'h00, 0, 1, 3, 2'd0, 0,   8'h3C, 0, 0, 0, 0);
    tick("amt0_idle", 0, 0, 8'h00, 0, 0, 0, 2'd0, 0,   8'h3C, 0, 0, 0, 0);
    // Shift_En while busy adds no step; Reset mid-shift clears everything
    tick("ld_0f",     0, 1, 8'h0F, 0, 0, 0, 2'd1, 0,   8'h0F, 0, 0, 0, 1);
    tick("st_asr3b",  0, 0, 8'h00, 0, 1, 3, 2'd1, 0,   8'h0F, 1, 0, 3, 1);
    tick("se_busy",   0, 0, 8'h00, 1, 0, 0, 2'd1, 0,   8'h07, 1, 0, 2, 1);
    tick("rst_mid",   1, 0, 8'h00, 0, 1, 3, 2'd1, 0,   8'h00, 0, 0, 0, 0);
    tick("rst_after", 0, 0, 8'h00, 0, 0, 0, 2'd1, 0,   8'h00, 0, 0, 0, 0);

    repeat (3) @(posedge Clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain   got %0d pending expectations exp 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout got no finish exp finish before 100000");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
